// File: rtl/sparc_mem_sequencer.sv
// sparc_mem_sequencer: arbitrates the single RAM port between instruction fetch and data load/store
// Ports:
//   i_clk, i_clr_n                 clock (rising edge), asynchronous active-low reset
//   i_if_req / o_if_ack            fetch request (held until ack) / one-cycle IR-loaded pulse
//   i_d_req, i_d_rw, i_d_type      data request, 1=read 0=write, size 00 byte..11 dword
//   o_d_ack                        one-cycle data-complete pulse
//   i_mar_lo                       MAR[2:0] of the pending access for the alignment check
//   i_moc / o_mov                  RAM handshake: operation complete / operation valid
//   o_rw, o_type                   RAM direction (1=read) and access size (fetch is word)
//   o_ir_ld, o_mdr_ld, o_mm        IR load, MDR load, MDR mux select (0=RAM data)
//   o_err                          one-cycle pulse on misalignment or timeout
//   o_busy                         high in every state except IDLE
// Optional feature: define MEM_TIMEOUT_EN to abort an ACCESS that sees no MOC
// within TIMEOUT_CYCLES cycles; otherwise ACCESS waits for MOC indefinitely.
module sparc_mem_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TCNT_W         = 5
) (
  input  logic       i_clk,
  input  logic       i_clr_n,
  input  logic       i_if_req,
  output logic       o_if_ack,
  input  logic       i_d_req,
  input  logic       i_d_rw,
  input  logic [1:0] i_d_type,
  output logic       o_d_ack,
  input  logic [2:0] i_mar_lo,
  input  logic       i_moc,
  output logic       o_mov,
  output logic       o_rw,
  output logic [1:0] o_type,
  output logic       o_ir_ld,
  output logic       o_mdr_ld,
  output logic       o_mm,
  output logic       o_err,
  output logic       o_busy
);
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ACCESS, S_DONE, S_RELEASE, S_ERR
  } state_t;

  state_t     r_state, w_next;
  logic       r_owner_d;
  logic       r_rw;
  logic [1:0] r_type;
  logic       w_misalign;
  logic       w_timeout;

  // byte accesses are never misaligned; larger sizes need their low address bits clear
  assign w_misalign = (r_type == 2'b01 && i_mar_lo[0])
                   || (r_type == 2'b10 && |i_mar_lo[1:0])
                   || (r_type == 2'b11 && |i_mar_lo);

`ifdef MEM_TIMEOUT_EN
  logic [TCNT_W-1:0] r_cnt;
  // the counter holds zero outside ACCESS, so it is clear on every entry;
  // matching TIMEOUT_CYCLES-1 ends ACCESS after exactly TIMEOUT_CYCLES cycles
  assign w_timeout = (r_cnt == TCNT_W'(TIMEOUT_CYCLES - 1)) && !i_moc;
  always_ff @(posedge i_clk or negedge i_clr_n)
    if (!i_clr_n) r_cnt <= '0;
    else          r_cnt <= (r_state == S_ACCESS) ? r_cnt + 1'b1 : '0;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_state   <= S_IDLE;
      r_owner_d <= 1'b0;
      r_rw      <= 1'b1;
      r_type    <= 2'b10;
    end else begin
      r_state <= w_next;
      // data has priority; a losing fetch stays pending and wins the next IDLE
      if (r_state == S_IDLE && (i_d_req || i_if_req)) begin
        r_owner_d <= i_d_req;
        r_rw      <= i_d_req ? i_d_rw : 1'b1;
        r_type    <= i_d_req ? i_d_type : 2'b10;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = (i_d_req || i_if_req) ? S_CHECK : S_IDLE;
      S_CHECK:   w_next = w_misalign ? S_ERR : S_ACCESS;
      S_ACCESS:  w_next = i_moc ? S_DONE : (w_timeout ? S_ERR : S_ACCESS);
      S_DONE:    w_next = S_RELEASE;
      S_RELEASE: w_next = i_moc ? S_RELEASE : S_IDLE;
      S_ERR:     w_next = S_RELEASE;
      default:   w_next = S_IDLE;
    endcase
  end

  // MOV stays up through DONE so RAM data is stable while IR/MDR load
  assign o_mov    = (r_state == S_ACCESS) || (r_state == S_DONE);
  assign o_rw     = r_rw;
  assign o_type   = r_type;
  assign o_if_ack = (r_state == S_DONE) && !r_owner_d;
  assign o_ir_ld  = o_if_ack;
  assign o_d_ack  = (r_state == S_DONE) && r_owner_d;
  assign o_mdr_ld = o_d_ack && r_rw;
  assign o_mm     = 1'b0;
  assign o_err    = (r_state == S_ERR);
  assign o_busy   = (r_state != S_IDLE);
endmodule
